// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped halfword-indexed instruction cache responder
// One fetch in flight; a miss issues a single 32-bit read and fills the entry.
module icache_responder #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        fetch_able,
    input  logic [31:0] fetch_pc,
    input  logic        clear,
    output logic        ins_ready,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 32 - INDEX_BITS - 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MISS  = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        ins_ready_q, ins_ready_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] ins_pc_q, ins_pc_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        fill_en;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      data_q  [ENTRIES];

    // Bit 0 of the fetch address never reaches the cache.
    logic [31:0]           pc_al;
    logic [INDEX_BITS-1:0] look_idx, fill_idx;
    logic [TAG_W-1:0]      look_tag, fill_tag;
    logic                  look_hit;

    assign pc_al    = fetch_pc & ~32'h1;
    assign look_idx = pc_al[INDEX_BITS:1];
    assign look_tag = pc_al[31:INDEX_BITS+1];
    assign look_hit = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    assign fill_idx = mem_addr_q[INDEX_BITS:1];
    assign fill_tag = mem_addr_q[31:INDEX_BITS+1];

    always_comb begin
        state_d     = state_q;
        ins_ready_d = 1'b0;
        ins_d       = ins_q;
        ins_pc_d    = ins_pc_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        fill_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fetch_able && !clear) begin
                    if (look_hit) begin
                        ins_ready_d = 1'b1;
                        ins_d       = data_q[look_idx];
                        ins_pc_d    = pc_al;
                        state_d     = ST_DONE;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_al;
                        state_d    = ST_MISS;
                    end
                end
            end
            ST_MISS: begin
                if (mem_done) begin
                    fill_en   = 1'b1;
                    mem_req_d = 1'b0;
                    if (clear) begin
                        state_d = ST_IDLE;
                    end else begin
                        ins_ready_d = 1'b1;
                        ins_d       = mem_data;
                        ins_pc_d    = mem_addr_q;
                        state_d     = ST_DONE;
                    end
                end else if (clear) begin
                    // The read cannot be withdrawn; keep requesting and just drop the answer.
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (mem_done) begin
                    fill_en   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            ins_ready_q <= 1'b0;
            ins_q       <= 32'h0;
            ins_pc_q    <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'h0;
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (rdy_in) begin
            state_q     <= state_d;
            ins_ready_q <= ins_ready_d;
            ins_q       <= ins_d;
            ins_pc_q    <= ins_pc_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            if (fill_en) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_data;
        end
    end

    assign ins_ready = ins_ready_q;
    assign ins       = ins_q;
    assign ins_pc    = ins_pc_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - randomized self-checking bench for icache_responder
module tb_icache_responder;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, fetch_able, clear, mem_done;
    logic [31:0] fetch_pc, mem_data;
    logic        ins_ready, mem_req;
    logic [31:0] ins, ins_pc, mem_addr;

    int n_cmp = 0;
    int n_err = 0;

    // Reference cache contents, indexed by halfword address modulo 64 entries.
    bit          m_valid [64];
    logic [31:0] m_pc    [64];
    logic [31:0] m_data  [64];

    icache_responder #(.INDEX_BITS(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .fetch_able(fetch_able), .fetch_pc(fetch_pc), .clear(clear),
        .ins_ready(ins_ready), .ins(ins), .ins_pc(ins_pc),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_done(mem_done), .mem_data(mem_data)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int entry_of(input logic [31:0] pc);
        return int'((pc / 2) % 64);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int e = entry_of(pc);
        return m_valid[e] && ((m_pc[e] / 128) == (pc / 128));
    endfunction

    task automatic model_fill(input logic [31:0] pa, input logic [31:0] d);
        int e = entry_of(pa);
        m_valid[e] = 1'b1;
        m_pc[e]    = pa;
        m_data[e]  = d;
    endtask

    // clr_at: -1 = no flush, k = flush during the k-th wait cycle (k == lat: same cycle as mem_done)
    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] d, input int lat, input int clr_at);
        logic [31:0] pa = pc & ~32'h1;
        bit aborted = 1'b0;
        fetch_able = 1'b1;
        fetch_pc   = pc;
        if (model_hit(pa)) begin
            tick();
            check("hit_rdy", {31'b0, ins_ready}, 32'h1);
            check("hit_ins", ins, m_data[entry_of(pa)]);
            check("hit_pc", ins_pc, pa);
            check("hit_noreq", {31'b0, mem_req}, 32'h0);
            tick();
            check("done_rdy", {31'b0, ins_ready}, 32'h0);
            check("done_noreq", {31'b0, mem_req}, 32'h0);
            fetch_able = 1'b0;
            return;
        end
        tick();
        check("miss_req", {31'b0, mem_req}, 32'h1);
        check("miss_addr", mem_addr, pa);
        check("miss_rdy", {31'b0, ins_ready}, 32'h0);
        for (int k = 0; k < lat; k++) begin
            if (k == clr_at) begin
                clear = 1'b1;
                fetch_able = 1'b0;
                aborted = 1'b1;
            end
            tick();
            clear = 1'b0;
            check("wait_req", {31'b0, mem_req}, 32'h1);
            check("wait_addr", mem_addr, pa);
            check("wait_rdy", {31'b0, ins_ready}, 32'h0);
        end
        if (clr_at == lat) begin
            clear = 1'b1;
            fetch_able = 1'b0;
            aborted = 1'b1;
        end
        mem_done = 1'b1;
        mem_data = d;
        tick();
        mem_done = 1'b0;
        clear = 1'b0;
        model_fill(pa, d);
        check("fill_req", {31'b0, mem_req}, 32'h0);
        if (!aborted) begin
            check("fill_rdy", {31'b0, ins_ready}, 32'h1);
            check("fill_ins", ins, d);
            check("fill_pc", ins_pc, pa);
            tick();
            check("fdone_rdy", {31'b0, ins_ready}, 32'h0);
            fetch_able = 1'b0;
        end else begin
            check("abort_rdy", {31'b0, ins_ready}, 32'h0);
            tick();
            check("abort_idle_rdy", {31'b0, ins_ready}, 32'h0);
            check("abort_idle_req", {31'b0, mem_req}, 32'h0);
        end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; fetch_able = 1'b0; fetch_pc = 32'h0;
        clear = 1'b0; mem_done = 1'b0; mem_data = 32'h0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        tick();
        tick();
        rst_in = 1'b0;
        check("rst_rdy", {31'b0, ins_ready}, 32'h0);
        check("rst_ins", ins, 32'h0);
        check("rst_pc", ins_pc, 32'h0);
        check("rst_req", {31'b0, mem_req}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);

        // First fill, then hit, then same-index conflicts.
        do_fetch(32'h0, 32'h0000_0013, 2, -1);
        do_fetch(32'h0, 32'h0, 0, -1);
        do_fetch(32'h4, 32'h1111_0004, 1, -1);
        do_fetch(32'h84, 32'h2222_0084, 1, -1);
        do_fetch(32'h4, 32'h3333_0004, 0, -1);
        do_fetch(32'h4, 32'h0, 0, -1);

        // Flush mid-miss, memory answers later; entry is still filled.
        do_fetch(32'h40, 32'h4444_0040, 4, 0);
        do_fetch(32'h40, 32'h0, 0, -1);

        // Flush in the same cycle as a new request drops it.
        fetch_able = 1'b1; fetch_pc = 32'h100; clear = 1'b1;
        tick();
        clear = 1'b0; fetch_able = 1'b0;
        check("idle_clr_rdy", {31'b0, ins_ready}, 32'h0);
        check("idle_clr_req", {31'b0, mem_req}, 32'h0);
        tick();
        check("idle_clr_req2", {31'b0, mem_req}, 32'h0);

        // Stall with a pending hit request: nothing happens until rdy returns.
        fetch_able = 1'b1; fetch_pc = 32'h0; rdy_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_rdy", {31'b0, ins_ready}, 32'h0);
        end
        rdy_in = 1'b1;
        tick();
        check("stall_hit_rdy", {31'b0, ins_ready}, 32'h1);
        check("stall_hit_ins", ins, 32'h0000_0013);
        tick();
        check("stall_done_rdy", {31'b0, ins_ready}, 32'h0);
        fetch_able = 1'b0;

        // Halfword miss; a mem_done pulse during a stall is not seen.
        fetch_able = 1'b1; fetch_pc = 32'h2;
        tick();
        check("hw_req", {31'b0, mem_req}, 32'h1);
        check("hw_addr", mem_addr, 32'h2);
        rdy_in = 1'b0; mem_done = 1'b1; mem_data = 32'hDEAD_BEEF;
        tick();
        mem_done = 1'b0;
        tick();
        rdy_in = 1'b1;
        tick();
        check("hw_stall_req", {31'b0, mem_req}, 32'h1);
        check("hw_stall_rdy", {31'b0, ins_ready}, 32'h0);
        mem_done = 1'b1; mem_data = 32'h5555_0002;
        tick();
        mem_done = 1'b0;
        model_fill(32'h2, 32'h5555_0002);
        check("hw_rdy", {31'b0, ins_ready}, 32'h1);
        check("hw_ins", ins, 32'h5555_0002);
        check("hw_pc", ins_pc, 32'h2);
        tick();
        fetch_able = 1'b0;
        check("hw_done_rdy", {31'b0, ins_ready}, 32'h0);
        do_fetch(32'h3, 32'h0, 0, -1);

        // Randomized traffic over a few tags so hits and conflicts both occur.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] pc;
            int lat, ca;
            pc = ($urandom_range(0, 3) * 128) + ($urandom_range(0, 63) * 2) + $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) pc = pc + ($urandom & 32'hFFFF_0000);
            lat = $urandom_range(0, 4);
            ca  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lat) : -1;
            do_fetch(pc, $urandom, lat, ca);
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
